usb_fs_tx_phy: RTL and testbench
================================

// Module: usb_fs_tx_phy
// PURPOSE
// - Full-speed USB transmit line driver: serialises packet bytes onto the dedicated D+/D- pins
//   (usb_dp_tx_o/usb_dn_tx_o/usb_dp_en_o/usb_dn_en_o).
// - Adds SYNC, LSB-first serialisation, bit stuffing, NRZI encoding and EOP.
// - Sits between the packet/protocol engine and the pad ring; it is the transmit counterpart of
//   the usb_dp_rx_i/usb_dn_rx_i receive path.
// PARAMETERS
// - CLK_PER_BIT  4  clk cycles per USB bit (48 MHz clk -> 12 Mb/s); legal values >= 2
// PORTS
// - clk          in   1  clock; all logic on the rising edge
// - rst_n        in   1  reset; synchronous, active-low
// - tx_valid_i   in   1  byte offered on tx_data_i
// - tx_data_i    in   8  packet byte (PID first), sent LSB first
// - tx_last_i    in   1  qualifies tx_data_i as the final byte of the packet
// - tx_ready_o   out  1  byte accepted when tx_valid_i & tx_ready_o at a rising edge
// - tx_busy_o    out  1  high from packet start until the line is released
// - tx_err_o     out  1  one-cycle pulse on underrun abort
// - usb_dp_tx_o  out  1  D+ drive value
// - usb_dn_tx_o  out  1  D- drive value
// - usb_dp_en_o  out  1  D+ output enable
// - usb_dn_en_o  out  1  D- output enable; always equal to usb_dp_en_o
// BEHAVIOUR
// - Reset values (rst_n low at an edge):
//   - tx_ready_o=1, tx_busy_o=0, tx_err_o=0
//   - dp_tx=1, dn_tx=0 (J), en=0
//   - state IDLE; hold buffer empty; all counters 0.
//   - Reset mid-packet takes effect at that edge; no EOP is sent.
// - Line symbols: J = dp1/dn0, K = dp0/dn1, SE0 = dp0/dn0. All pin outputs are registered.
// - Pin outputs change only at bit boundaries (every CLK_PER_BIT cycles, counted from packet start).
// - One-byte hold buffer plus an 8-bit shift register.
//   - tx_ready_o = hold empty & no tx_last byte accepted yet in the current packet.
//   - After the last byte is accepted, tx_ready_o stays 0 until IDLE is re-entered.
// - FSM states: IDLE -> SYNC -> DATA -> EOP -> IDLE.
//   - IDLE:
//     - Handshake on tx_valid_i & tx_ready_o latches the byte into hold.
//     - Next cycle: en=1, first SYNC bit on the line, tx_busy_o=1.
//   - SYNC:
//     - Sends 8'h80 LSB-first through the NRZI path, giving KJKJKJKK.
//     - NRZI: data 0 toggles the line, data 1 holds it; the encoder starts from J.
//   - DATA:
//     - At each byte boundary, hold moves to the shift register and hold becomes empty.
//     - tx_valid_i may refill hold in the same cycle; back-to-back bytes produce no gap bits.
//   - Bit stuffing:
//     - The ones counter increments on each 1, clears on each 0 and on a stuffed bit.
//     - It includes the final 1 of SYNC.
//     - After 6 consecutive 1s, a stuffed 0 is inserted (line toggles) and the shift register
//       pauses for one bit.
//     - A stuff bit owed after the final data bit is sent before EOP.
//   - Underrun:
//     - Condition: a byte boundary with hold empty and the last byte not yet sent.
//     - Response: go to EOP, pulse tx_err_o for 1 cycle at the transition.
//   - EOP:
//     - 2 bit times SE0, then 1 bit time J.
//     - Then en=0, tx_busy_o=0, IDLE; tx_ready_o=1 in the same cycle.
//     - A new packet may start on the next handshake.
// - tx_valid_i is ignored while tx_ready_o=0. tx_data_i/tx_last_i are sampled only on the handshake.
// - Single-byte packets are legal: tx_last_i is asserted on the first byte.
// TESTING
// - Bench samples the line at each bit boundary; tests use CLK_PER_BIT=4.
// - 1: Packet {8'h00, last}:
//   - Line shows KJKJKJKK, then 8 toggles (JKJKJKJK), SE0, SE0, J.
//   - en high for exactly 19*4 cycles; tx_busy_o has the same span.
// - 2: Packet {8'hFF, last}:
//   - One stuffed toggle follows the 5th data bit (6th 1 counting SYNC).
//   - 17 bits before EOP; en high for 20*4 cycles.
// - 3: Packet {8'hA5, 8'h3C, 8'hC3 last} with tx_valid_i held high:
//   - Decoded NRZI bytes match; no idle bits between bytes.
//   - tx_ready_o low from acceptance of 8'hC3 until IDLE.
// - 4: Underrun: send 8'h2D without last, then drop tx_valid_i:
//   - After 8'h2D completes: tx_err_o 1-cycle pulse, SE0 SE0 J, then IDLE.
// - 5: rst_n low for 1 cycle during the 2nd data byte:
//   - Next edge: en=0, J, tx_ready_o=1, tx_busy_o=0; the following packet transmits correctly.
// - 6: Stuff at packet end: {8'hFC, last} (six trailing 1s):
//   - Stuffed toggle is sent, then the EOP.

Source files
------------

// File: rtl/usb_fs_tx_phy.sv
// Full-speed USB transmit line driver: SYNC, LSB-first serialisation, bit stuffing,
// NRZI encoding and EOP onto the D+/D- pins, fed by a one-byte hold buffer.
module usb_fs_tx_phy #(
  parameter int CLK_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_last_i,
  output logic       tx_ready_o,
  output logic       tx_busy_o,
  output logic       tx_err_o,
  output logic       usb_dp_tx_o,
  output logic       usb_dn_tx_o,
  output logic       usb_dp_en_o,
  output logic       usb_dn_en_o
);

  localparam int CW = (CLK_PER_BIT > 2) ? $clog2(CLK_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, SYNC, DATA, EOP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    hold_data;
  logic          hold_valid;
  logic          hold_last;
  logic [7:0]    shift;
  logic [3:0]    bit_cnt;
  logic          cur_last;
  logic          last_seen;
  logic [2:0]    ones;
  logic [1:0]    eop_cnt;
  logic          level;
  logic          line_dp;
  logic          line_dn;
  logic          line_en;
  logic          busy;
  logic          err;

  logic handshake;
  logic bit_end;
  logic data_bit;
  logic next_level;

  assign tx_ready_o  = ~hold_valid & ~last_seen;
  assign handshake   = tx_valid_i & tx_ready_o;
  assign bit_end     = (cnt == CW'(CLK_PER_BIT - 1));
  assign tx_busy_o   = busy;
  assign tx_err_o    = err;
  assign usb_dp_tx_o = line_dp;
  assign usb_dn_tx_o = line_dn;
  assign usb_dp_en_o = line_en;
  assign usb_dn_en_o = line_en;

  // Next bit to put on the line: stuff bit, current shift bit, or first bit of the hold byte.
  // In IDLE this is bit 0 of the SYNC pattern 8'h80.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    data_bit = 1'b0;
    if (state != IDLE) begin
      if (ones == 3'd6)          data_bit = 1'b0;
      else if (bit_cnt != 4'd8)  data_bit = shift[0];
      else                       data_bit = hold_data[0];
    end
  end

  // NRZI: a 0 toggles the line level, a 1 holds it.
  assign next_level = data_bit ? level : ~level;

  // NOTE: all state updates use non-blocking assignments; reset is synchronous and
  // clears every register, hold data included, so a reset never leaves stale bytes behind.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      hold_data  <= '0;
      hold_valid <= 1'b0;
      hold_last  <= 1'b0;
      shift      <= '0;
      bit_cnt    <= '0;
      cur_last   <= 1'b0;
      last_seen  <= 1'b0;
      ones       <= '0;
      eop_cnt    <= '0;
      level      <= 1'b1;
      line_dp    <= 1'b1;
      line_dn    <= 1'b0;
      line_en    <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      if (handshake) begin
        hold_data  <= tx_data_i;
        hold_valid <= 1'b1;
        hold_last  <= tx_last_i;
        if (tx_last_i) last_seen <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (handshake) begin
            state   <= SYNC;
            line_en <= 1'b1;
            busy    <= 1'b1;
            cnt     <= '0;
            shift   <= 8'h40;
            bit_cnt <= 4'd1;
            ones    <= '0;
            level   <= next_level;
            line_dp <= next_level;
            line_dn <= ~next_level;
          end
        end
        SYNC, DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (ones == 3'd6) begin
              // Stuffed 0: the shift register holds its position for this bit.
              ones    <= '0;
              level   <= next_level;
              line_dp <= next_level;
              line_dn <= ~next_level;
            end else if (bit_cnt != 4'd8) begin
              shift   <= {1'b0, shift[7:1]};
              bit_cnt <= bit_cnt + 4'd1;
              ones    <= data_bit ? ones + 3'd1 : 3'd0;
              level   <= next_level;
              line_dp <= next_level;
              line_dn <= ~next_level;
            end else if (hold_valid) begin
              shift      <= {1'b0, hold_data[7:1]};
              bit_cnt    <= 4'd1;
              cur_last   <= hold_last;
              hold_valid <= 1'b0;
              state      <= DATA;
              ones       <= data_bit ? ones + 3'd1 : 3'd0;
              level      <= next_level;
              line_dp    <= next_level;
              line_dn    <= ~next_level;
            end else begin
              // Byte boundary with nothing queued: normal end, or underrun if no last byte.
              state   <= EOP;
              eop_cnt <= '0;
              line_dp <= 1'b0;
              line_dn <= 1'b0;
              if (!cur_last) begin
                err       <= 1'b1;
                last_seen <= 1'b1;
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        EOP: begin
          if (bit_end) begin
            cnt <= '0;
            unique case (eop_cnt)
              2'd0: eop_cnt <= 2'd1;
              2'd1: begin
                eop_cnt <= 2'd2;
                line_dp <= 1'b1;
                line_dn <= 1'b0;
              end
              default: begin
                state     <= IDLE;
                line_en   <= 1'b0;
                busy      <= 1'b0;
                last_seen <= 1'b0;
                cur_last  <= 1'b0;
                eop_cnt   <= '0;
                ones      <= '0;
                bit_cnt   <= '0;
                level     <= 1'b1;
              end
            endcase
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_fs_tx_phy.sv
// Directed bench for usb_fs_tx_phy: captures the line once per bit time and compares it
// with hand-derived NRZI symbol strings (J, K, 0 for SE0).
module tb_usb_fs_tx_phy;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_last = 1'b0;
  logic       tx_ready, tx_busy, tx_err;
  logic       dp, dn, dp_en, dn_en;

  int pass_cnt = 0;
  int check_cnt = 0;

  string cap_syms;
  int    cap_en, cap_busy, cap_err, cap_err_cyc, cap_glitch, rdy_high;
  bit    cap_timeout, feed_timeout;

  always #5 clk = ~clk;

  usb_fs_tx_phy #(.CLK_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_valid_i  (tx_valid),
    .tx_data_i   (tx_data),
    .tx_last_i   (tx_last),
    .tx_ready_o  (tx_ready),
    .tx_busy_o   (tx_busy),
    .tx_err_o    (tx_err),
    .usb_dp_tx_o (dp),
    .usb_dn_tx_o (dn),
    .usb_dp_en_o (dp_en),
    .usb_dn_en_o (dn_en)
  );

  function automatic string sym(input logic a, input logic b);
    case ({a, b})
      2'b10:   return "J";
      2'b01:   return "K";
      2'b00:   return "0";
      default: return "X";
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_str(input string tag, input string obs, input string exp);
    check_cnt++;
    assert (obs == exp) pass_cnt++;
    else $error("FAIL %s: observed %s expected %s", tag, obs, exp);
  endtask

  // {en_dp, en_dn, dp, dn, ready, busy, err}; idle/reset value is 7'b0010100
  function automatic logic [6:0] idle_vec();
    return {dp_en, dn_en, dp, dn, tx_ready, tx_busy, tx_err};
  endfunction

  task automatic wait_ready();
    int t = 0;
    while (!tx_ready && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (!tx_ready) feed_timeout = 1'b1;
  endtask

  // Offers n bytes, holding tx_valid high between them; after a last byte, counts
  // cycles with tx_ready high until the line is released.
  task automatic feed(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                      input int n, input bit last);
    logic [7:0] bytes [3];
    int t;
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
    rdy_high = 0;
    for (int i = 0; i < n; i++) begin
      tx_valid = 1'b1;
      tx_data  = bytes[i];
      tx_last  = last && (i == n - 1);
      wait_ready();
      @(posedge clk); #1;
    end
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    if (last) begin
      t = 0;
      while (dp_en && t < 400) begin
        if (tx_ready) rdy_high++;
        @(posedge clk); #1;
        t++;
      end
    end
  endtask

  task automatic capture();
    int cyc;
    logic [1:0] first;
    cap_syms = ""; cap_en = 0; cap_busy = 0; cap_err = 0; cap_err_cyc = -1;
    cap_glitch = 0; cap_timeout = 1'b0;
    cyc = 0;
    while (!dp_en && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!dp_en) begin
      cap_timeout = 1'b1;
      return;
    end
    cyc = 0;
    first = 2'b11;
    while (dp_en && cyc < 400) begin
      if (cyc % CPB == 0) begin
        first = {dp, dn};
        cap_syms = {cap_syms, sym(dp, dn)};
      end else if ({dp, dn} !== first) begin
        cap_glitch++;
      end
      if (dp_en !== dn_en) cap_glitch++;
      if (tx_busy) cap_busy++;
      if (tx_err) begin
        cap_err++;
        cap_err_cyc = cyc;
      end
      cap_en++;
      @(posedge clk); #1;
      cyc++;
    end
    if (dp_en) cap_timeout = 1'b1;
  endtask

  task automatic packet_test(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input int n, input bit last,
                             input string exp_syms, input int exp_bits, input int exp_err);
    feed_timeout = 1'b0;
    fork
      feed(b0, b1, b2, n, last);
      capture();
    join
    check({tag, "_timeout"}, {30'd0, cap_timeout, feed_timeout}, 32'd0);
    check_str({tag, "_line"}, cap_syms, exp_syms);
    check({tag, "_en_cycles"}, cap_en, exp_bits * CPB);
    check({tag, "_busy_cycles"}, cap_busy, exp_bits * CPB);
    check({tag, "_glitch"}, cap_glitch, 0);
    check({tag, "_err_pulses"}, cap_err, exp_err);
    check({tag, "_idle_after"}, idle_vec(), 7'b0010100);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_state", idle_vec(), 7'b0010100);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single zero byte -> SYNC, eight toggles, EOP
    packet_test("p00", 8'h00, 8'h00, 8'h00, 1, 1'b1,
                "KJKJKJKKJKJKJKJK00J", 19, 0);
    check("p00_ready_low", rdy_high, 0);

    // 2: all ones -> stuffed toggle after 5th data bit
    packet_test("pFF", 8'hFF, 8'h00, 8'h00, 1, 1'b1,
                "KJKJKJKKKKKKKJJJJ00J", 20, 0);

    // 3: three back-to-back bytes, valid held high
    packet_test("p3b", 8'hA5, 8'h3C, 8'hC3, 3, 1'b1,
                "KJKJKJKKKJJKJJKKJKKKKKJKKKJKJKKK00J", 35, 0);
    check("p3b_ready_low_after_last", rdy_high, 0);

    // 4: underrun after 8'h2D -> err pulse at the first SE0
    packet_test("urun", 8'h2D, 8'h00, 8'h00, 1, 1'b0,
                "KJKJKJKKKJJJKKJK00J", 19, 1);
    check("urun_err_cycle", cap_err_cyc, 16 * CPB);

    // 5: reset during 2nd data byte, then a clean packet
    feed_timeout = 1'b0;
    tx_valid = 1'b1; tx_data = 8'h11; tx_last = 1'b0;
    wait_ready();
    @(posedge clk); #1;
    tx_data = 8'h22; tx_last = 1'b1;
    repeat (68) @(posedge clk);
    #1;
    check("rst_mid_en_before", {dp_en, tx_busy}, 2'b11);
    tx_valid = 1'b0; tx_last = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_state", idle_vec(), 7'b0010100);
    check("rst_mid_feed_timeout", {31'd0, feed_timeout}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    packet_test("post_rst", 8'h00, 8'h00, 8'h00, 1, 1'b1,
                "KJKJKJKKJKJKJKJK00J", 19, 0);

    // 6: six trailing ones -> stuff bit before EOP
    packet_test("pFC", 8'hFC, 8'h00, 8'h00, 1, 1'b1,
                "KJKJKJKKJKKKKKKKJ00J", 20, 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
